htif_burst: RTL and testbench

Parametrised host-interface bridge between a byte-serial host link (UART/JTAG FIFO side) and the core's single-outstanding request/response bus. It is the successor to the fixed 32-bit serial bridge:
- data and address widths are parameters;
- bursts of up to 256 words are supported;
- write bursts return an acknowledge byte and read bursts return a checksum byte;
- unknown commands are explicitly NAKed.

---
 rtl/htif_burst_if.sv | 41 ++++
 rtl/htif_burst.sv | 181 ++++++++++++++++++
 tb/tb_htif_burst.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/htif_burst_if.sv
// Host byte link, core request/response bus and host tx link of the burst bridge.
// Latency: none, wires only.
// Backpressure: rx/tx use valid/ready; bus requests wait on bus_req_ready.
interface htif_burst_if #(
    parameter int DATA_BYTES = 4,
    parameter int ADDR_BYTES = 4
);
    logic                      rx_ready;
    logic                      rx_valid;
    logic [7:0]                rx_data;
    logic                      bus_req_ready;
    logic                      bus_req_read;
    logic                      bus_req_write;
    logic [8*ADDR_BYTES-1:0]   bus_req_address;
    logic [8*DATA_BYTES-1:0]   bus_req_data;
    logic                      bus_res_valid;
    logic [8*DATA_BYTES-1:0]   bus_res_data;
    logic                      tx_ready;
    logic                      tx_valid;
    logic [7:0]                tx_data;

    modport master (
        output rx_ready,
        input  rx_valid, rx_data,
        input  bus_req_ready,
        output bus_req_read, bus_req_write, bus_req_address, bus_req_data,
        input  bus_res_valid, bus_res_data,
        input  tx_ready,
        output tx_valid, tx_data
    );

    modport slave (
        input  rx_ready,
        output rx_valid, rx_data,
        output bus_req_ready,
        input  bus_req_read, bus_req_write, bus_req_address, bus_req_data,
        output bus_res_valid, bus_res_data,
        output tx_ready,
        input  tx_valid, tx_data
    );
endinterface

// File: rtl/htif_burst.sv
// Byte-serial host command bridge issuing burst reads/writes on a single-outstanding bus.
// Latency: bus request one cycle after the completing host byte; tx byte one cycle after read data.
// Backpressure: rx stalls outside command/data collection; requests hold until ready; tx holds until ready.
module htif_burst #(
    parameter int DATA_BYTES = 4,
    parameter int ADDR_BYTES = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    htif_burst_if.master hif,
    output logic [3:0]   s
);
    localparam int DW   = 8 * DATA_BYTES;
    localparam int AW   = 8 * ADDR_BYTES;
    localparam int MAXB = (DATA_BYTES > ADDR_BYTES) ? DATA_BYTES : ADDR_BYTES;
    localparam int IW   = (MAXB > 1) ? $clog2(MAXB) : 1;
    localparam logic [IW-1:0] D_LAST    = IW'(DATA_BYTES - 1);
    localparam logic [IW-1:0] A_LAST    = IW'(ADDR_BYTES - 1);
    localparam logic [AW-1:0] ADDR_STEP = AW'(DATA_BYTES);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_ADDR  = 4'd1,
        S_LEN   = 4'd2,
        S_WDATA = 4'd3,
        S_WREQ  = 4'd4,
        S_RREQ  = 4'd5,
        S_RWAIT = 4'd6,
        S_RSEND = 4'd7,
        S_SUM   = 4'd8,
        S_ACK   = 4'd9,
        S_NAK   = 4'd10
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [AW-1:0]  stage_q, stage_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic [DW-1:0]  rdata_q, rdata_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [8:0]     cnt_q, cnt_d;
    logic [8:0]     len_q, len_d;
    logic [7:0]     sum_q, sum_d;
    logic [7:0]     tx_data_q, tx_data_d;
    logic           rx_ready_q, rx_ready_d;
    logic           tx_valid_q, tx_valid_d;
    logic           rd_q, rd_d;
    logic           wr_q, wr_d;
    logic           rx_fire, tx_fire;

    assign rx_fire = hif.rx_valid & rx_ready_q;
    assign tx_fire = tx_valid_q & hif.tx_ready;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        stage_d   = stage_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        sum_d     = sum_q;
        tx_data_d = tx_data_q;
        case (state_q)
            S_IDLE: if (rx_fire) begin
                idx_d = '0;
                case (hif.rx_data)
                    8'h61: state_d = S_ADDR;
                    8'h6E: state_d = S_LEN;
                    8'h77: begin state_d = S_WDATA; cnt_d = len_q; sum_d = '0; end
                    8'h72: begin state_d = S_RREQ;  cnt_d = len_q; sum_d = '0; end
                    default: begin state_d = S_NAK; tx_data_d = 8'h3F; end
                endcase
            end
            S_ADDR: if (rx_fire) begin
                // Bytes arrive LSB first; shifting down leaves byte 0 at the bottom.
                stage_d = (stage_q >> 8) | (AW'(hif.rx_data) << (AW - 8));
                if (idx_q == A_LAST) begin
                    addr_d  = stage_d;
                    state_d = S_IDLE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_LEN: if (rx_fire) begin
                len_d   = (hif.rx_data == 8'd0) ? 9'd256 : {1'b0, hif.rx_data};
                state_d = S_IDLE;
            end
            S_WDATA: if (rx_fire) begin
                wdata_d = (wdata_q >> 8) | (DW'(hif.rx_data) << (DW - 8));
                if (idx_q == D_LAST) state_d = S_WREQ;
                else                 idx_d   = idx_q + IW'(1);
            end
            S_WREQ: if (hif.bus_req_ready) begin
                addr_d = addr_q + ADDR_STEP;
                cnt_d  = cnt_q - 9'd1;
                idx_d  = '0;
                if (cnt_d == 9'd0) begin state_d = S_ACK; tx_data_d = 8'h6B; end
                else                     state_d = S_WDATA;
            end
            S_RREQ: if (hif.bus_req_ready) begin
                addr_d  = addr_q + ADDR_STEP;
                state_d = S_RWAIT;
            end
            S_RWAIT: if (hif.bus_res_valid) begin
                rdata_d   = hif.bus_res_data;
                tx_data_d = hif.bus_res_data[7:0];
                idx_d     = '0;
                state_d   = S_RSEND;
            end
            S_RSEND: if (tx_fire) begin
                sum_d = sum_q + tx_data_q;
                if (idx_q == D_LAST) begin
                    cnt_d = cnt_q - 9'd1;
                    if (cnt_d == 9'd0) begin state_d = S_SUM; tx_data_d = sum_d; end
                    else                     state_d = S_RREQ;
                end else begin
                    idx_d     = idx_q + IW'(1);
                    rdata_d   = rdata_q >> 8;
                    tx_data_d = rdata_d[7:0];
                end
            end
            S_SUM, S_ACK, S_NAK: if (tx_fire) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they stay low through reset.
    always_comb begin
        rx_ready_d = (state_d == S_IDLE) || (state_d == S_ADDR) ||
                     (state_d == S_LEN)  || (state_d == S_WDATA);
        tx_valid_d = (state_d == S_RSEND) || (state_d == S_SUM) ||
                     (state_d == S_ACK)   || (state_d == S_NAK);
        rd_d       = (state_d == S_RREQ);
        wr_d       = (state_d == S_WREQ);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            stage_q    <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            len_q      <= 9'd1;
            sum_q      <= '0;
            tx_data_q  <= '0;
            rx_ready_q <= 1'b0;
            tx_valid_q <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            stage_q    <= stage_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            sum_q      <= sum_d;
            tx_data_q  <= tx_data_d;
            rx_ready_q <= rx_ready_d;
            tx_valid_q <= tx_valid_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
        end
    end

    assign hif.rx_ready        = rx_ready_q;
    assign hif.tx_valid        = tx_valid_q;
    assign hif.tx_data         = tx_data_q;
    assign hif.bus_req_read    = rd_q;
    assign hif.bus_req_write   = wr_q;
    assign hif.bus_req_address = addr_q;
    assign hif.bus_req_data    = wdata_q;
    assign s                   = state_q;
endmodule

// File: tb/tb_htif_burst.sv
// Bench for htif_burst: random host commands against a transaction-level model of the bridge.
// Latency: n/a.
// Backpressure: randomised bus_req_ready and tx_ready stalls.
module tb_htif_burst;
    localparam int DB = 4;
    localparam int AB = 4;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] s;

    htif_burst_if #(.DATA_BYTES(DB), .ADDR_BYTES(AB)) hif ();

    htif_burst #(.DATA_BYTES(DB), .ADDR_BYTES(AB)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .hif     (hif),
        .s       (s)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          failures = 0;
    txn_t        exp_bus[$];
    txn_t        obs_bus[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  obs_tx[$];
    logic [31:0] rd_q[$];
    logic [31:0] dir_words[$];
    logic [31:0] m_addr = 32'h0;
    int          m_n = 1;
    bit          rand_ready = 1'b0;
    bit          rand_tx = 1'b0;
    bit          spurious_en = 1'b0;
    int          hold_cnt = 0;
    int          wr_wait = 0;
    int          stab_err = 0;
    int          both_err = 0;
    bit          rsp_pending = 1'b0;
    int          rsp_delay = 0;
    logic [31:0] rsp_word = 32'h0;
    bit          req_pend = 1'b0;
    txn_t        req_save;
    bit          tx_pend = 1'b0;
    logic [7:0]  tx_save = 8'h0;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Bus/tx monitor at negedge, bus slave and tx sink just after posedge.
    always begin
        @(negedge clock);
        if (reset_n) begin
            if (hif.bus_req_read && hif.bus_req_write) both_err++;
            if (req_pend) begin
                if (hif.bus_req_write !== req_save.wr || hif.bus_req_read !== !req_save.wr ||
                    hif.bus_req_address !== req_save.addr ||
                    (req_save.wr && hif.bus_req_data !== req_save.data)) stab_err++;
            end
            req_pend = 1'b0;
            if (hif.bus_req_write || hif.bus_req_read) begin
                req_save.wr   = hif.bus_req_write;
                req_save.addr = hif.bus_req_address;
                req_save.data = hif.bus_req_write ? hif.bus_req_data : 32'h0;
                if (hif.bus_req_ready) begin
                    obs_bus.push_back(req_save);
                    if (hif.bus_req_read) begin
                        rsp_pending = 1'b1;
                        rsp_word    = (rd_q.size() != 0) ? rd_q.pop_front() : 32'hDEADBEEF;
                        rsp_delay   = $urandom_range(0, 3);
                    end
                end else begin
                    req_pend = 1'b1;
                    if (hif.bus_req_write) wr_wait++;
                end
            end
            if (tx_pend && (!hif.tx_valid || hif.tx_data !== tx_save)) stab_err++;
            tx_pend = 1'b0;
            if (hif.tx_valid) begin
                if (hif.tx_ready) obs_tx.push_back(hif.tx_data);
                else begin tx_pend = 1'b1; tx_save = hif.tx_data; end
            end
        end else begin
            req_pend = 1'b0;
            tx_pend  = 1'b0;
        end
        @(posedge clock);
        #1;
        hif.bus_res_valid = 1'b0;
        if (!reset_n) rsp_pending = 1'b0;
        if (rsp_pending) begin
            if (rsp_delay == 0) begin
                hif.bus_res_valid = 1'b1;
                hif.bus_res_data  = rsp_word;
                rsp_pending = 1'b0;
            end else rsp_delay--;
        end else if (spurious_en && s != 4'd5 && s != 4'd6 && $urandom_range(0, 5) == 0) begin
            hif.bus_res_valid = 1'b1;
            hif.bus_res_data  = $urandom;
        end
        if ((hif.bus_req_write || hif.bus_req_read) && hold_cnt > 0) begin
            hif.bus_req_ready = 1'b0;
            hold_cnt--;
        end else begin
            hif.bus_req_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        hif.tx_ready = rand_tx ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        repeat ($urandom_range(0, 1)) @(negedge clock);
        @(negedge clock);
        hif.rx_valid = 1'b1;
        hif.rx_data  = b;
        while (!hif.rx_ready && t < 2000) begin @(negedge clock); t++; end
        if (t >= 2000) check("rx_accept", hif.rx_ready, 1);
        @(posedge clock);
        #1 hif.rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clock);
        while (s != 4'd0 && t < 20000) begin @(negedge clock); t++; end
        if (t >= 20000) check("idle_timeout", s, 0);
        repeat (3) @(negedge clock);
    endtask

    task automatic cmd_addr(input logic [31:0] a);
        send_byte(8'h61);
        for (int i = 0; i < AB; i++) send_byte(a[8*i +: 8]);
        m_addr = a;
    endtask

    task automatic cmd_len(input logic [7:0] l);
        send_byte(8'h6E);
        send_byte(l);
        m_n = (l == 8'd0) ? 256 : int'(l);
    endtask

    task automatic cmd_write();
        logic [31:0] w;
        send_byte(8'h77);
        for (int k = 0; k < m_n; k++) begin
            if (dir_words.size() != 0) w = dir_words.pop_front();
            else                       w = $urandom;
            exp_bus.push_back({1'b1, m_addr, w});
            m_addr += DB;
            for (int i = 0; i < DB; i++) send_byte(w[8*i +: 8]);
        end
        exp_tx.push_back(8'h6B);
        wait_idle();
    endtask

    task automatic cmd_read();
        logic [31:0] w;
        logic [7:0]  sum;
        sum = 8'h0;
        for (int k = 0; k < m_n; k++) begin
            if (dir_words.size() != 0) w = dir_words.pop_front();
            else                       w = $urandom;
            rd_q.push_back(w);
            exp_bus.push_back({1'b0, m_addr, 32'h0});
            m_addr += DB;
            for (int i = 0; i < DB; i++) begin
                exp_tx.push_back(w[8*i +: 8]);
                sum += w[8*i +: 8];
            end
        end
        exp_tx.push_back(sum);
        send_byte(8'h72);
        wait_idle();
    endtask

    task automatic cmd_nak(input logic [7:0] b);
        send_byte(b);
        exp_tx.push_back(8'h3F);
        wait_idle();
    endtask

    task automatic verify(input string tag);
        check({tag, "_nbus"}, obs_bus.size(), exp_bus.size());
        for (int i = 0; i < exp_bus.size() && i < obs_bus.size(); i++)
            check($sformatf("%s_bus%0d", tag, i), obs_bus[i], exp_bus[i]);
        check({tag, "_ntx"}, obs_tx.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < obs_tx.size(); i++)
            check($sformatf("%s_tx%0d", tag, i), obs_tx[i], exp_tx[i]);
        check({tag, "_addr"}, hif.bus_req_address, m_addr);
        check({tag, "_rx_ready"}, hif.rx_ready, 1);
        obs_bus.delete(); exp_bus.delete(); obs_tx.delete(); exp_tx.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s"},        s, 0);
        check({tag, "_rx_ready"}, hif.rx_ready, 0);
        check({tag, "_tx_valid"}, hif.tx_valid, 0);
        check({tag, "_rd"},       hif.bus_req_read, 0);
        check({tag, "_wr"},       hif.bus_req_write, 0);
        check({tag, "_addr"},     hif.bus_req_address, 0);
        check({tag, "_data"},     hif.bus_req_data, 0);
        check({tag, "_tx_data"},  hif.tx_data, 0);
    endtask

    initial begin
        logic [7:0]  b;
        logic [31:0] a;
        int          t;
        hif.rx_valid = 1'b0; hif.rx_data = 8'h0;
        hif.bus_req_ready = 1'b0; hif.bus_res_valid = 1'b0; hif.bus_res_data = 32'h0;
        hif.tx_ready = 1'b0;

        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        #1 check("rx_ready_at_release", hif.rx_ready, 0);
        @(posedge clock);
        #1 check("rx_ready_after_release", hif.rx_ready, 1);

        // Single write held off by three stalled cycles.
        cmd_addr(32'h10);
        dir_words.push_back(32'h12345678);
        hold_cnt = 3; wr_wait = 0;
        cmd_write();
        check("wr_hold_cycles", wr_wait, 3);
        verify("wr1");

        // Three-word read burst with known data.
        rand_tx = 1'b1;
        cmd_len(8'd3);
        cmd_addr(32'h100);
        dir_words.push_back(32'h04030201);
        dir_words.push_back(32'h08070605);
        dir_words.push_back(32'h0C0B0A09);
        cmd_read();
        if (obs_tx.size() != 0) check("rd3_checksum", obs_tx[obs_tx.size()-1], 8'h4E);
        verify("rd3");

        // Length byte 0 means 256 words, and it persists into the next read.
        rand_ready = 1'b1; spurious_en = 1'b1;
        cmd_len(8'd0);
        cmd_addr($urandom & 32'hFFFF_FFFC);
        cmd_write();
        verify("wr256");
        cmd_read();
        verify("rd256");

        // Unknown command.
        cmd_nak(8'h78);
        cmd_addr(32'h40);
        verify("nak");

        // Address wrap at the top of the space.
        cmd_addr(32'hFFFF_FFFC);
        cmd_len(8'd2);
        cmd_read();
        verify("wrap");

        for (int it = 0; it < 10; it++) begin
            case ($urandom_range(0, 4))
                0: cmd_addr($urandom);
                1: cmd_len(8'($urandom_range(1, 6)));
                2: cmd_write();
                3: cmd_read();
                default: begin
                    b = 8'($urandom);
                    if (b inside {8'h61, 8'h6E, 8'h77, 8'h72}) b = 8'h7A;
                    cmd_nak(b);
                end
            endcase
            verify($sformatf("rnd%0d", it));
        end

        // Reset in the middle of sending the second read word.
        cmd_len(8'd3);
        cmd_addr(32'h200);
        for (int k = 0; k < 3; k++) rd_q.push_back($urandom);
        send_byte(8'h72);
        t = 0;
        @(negedge clock);
        while (!(s == 4'd7 && obs_bus.size() == 2) && t < 2000) begin @(negedge clock); t++; end
        check("rst_reach_rsend2", s, 7);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("midrst");
        rd_q.delete(); obs_bus.delete(); exp_bus.delete(); obs_tx.delete(); exp_tx.delete();
        m_addr = 32'h0; m_n = 1;
        repeat (3) @(negedge clock);
        check_reset_outputs("midrst_hold");
        reset_n = 1'b1;
        @(posedge clock);
        #1 check("midrst_rx_ready", hif.rx_ready, 1);
        check("midrst_no_bus", obs_bus.size(), 0);
        check("midrst_no_tx", obs_tx.size(), 0);
        cmd_read();
        verify("post_rst");

        check("stability_errors", stab_err, 0);
        check("rd_wr_overlap", both_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
